// File: rtl/mac_out_buf_pkg.sv
// Shared widths and constants for the MAC output buffer.
package mac_out_buf_pkg;

  localparam int FP16_W   = 16;
  localparam int SIGN_BIT = 15;
  localparam int WORD_W   = 32;

  localparam logic [FP16_W-1:0] ZERO_FP16 = 16'h0000;

  // ReLU on an FP16 value: any result with the sign bit set (including -0.0) becomes +0.0.
  function automatic logic [FP16_W-1:0] relu_fp16(input logic [FP16_W-1:0] v);
    return v[SIGN_BIT] ? ZERO_FP16 : v;
  endfunction

endpackage

// File: rtl/mac_out_fifo.sv
// Synchronous FIFO of packed result words. The head is driven from the storage registers and reads
// as zero while the FIFO is empty.
module mac_out_fifo
  import mac_out_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_r;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count   = count_r;
  assign full    = (count_r == DEPTH[AW:0]);
  assign empty   = (count_r == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mac_out_buf.sv
// Output buffer behind MAC stage 5: optional ReLU, packs two FP16 results per 32-bit word,
// queues words for write-back and stalls the MAC pipeline when it cannot accept.
// Handshake: a MAC sample is consumed at a clock edge iff i_valid=1 and o_inhibit=0; a word
// leaves at a clock edge iff o_valid=1 and i_ready=1, and o_data holds while o_valid & ~i_ready.
module mac_out_buf
  import mac_out_buf_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [FP16_W-1:0]        i_conv,
  input  logic                     i_flush,
  output logic                     o_inhibit,
  output logic                     o_valid,
  output logic [WORD_W-1:0]        o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic [50:0]              o_transistor_num
);

  logic              half_vld;
  logic              flush_pend;
  logic [FP16_W-1:0] half_r;

  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              rd_en;
  logic              accept;
  logic              room;
  logic [FP16_W-1:0] sample;

  // Stall comes from registers only, so there is no input-to-inhibit combinational path.
  assign o_inhibit = fifo_full | flush_pend;
  assign accept    = i_valid & ~o_inhibit;
  assign sample    = RELU_EN ? relu_fp16(i_conv) : i_conv;
  assign rd_en     = o_valid & i_ready;
  // A full FIFO still has room for one word when its head leaves in the same cycle.
  assign room      = ~fifo_full | rd_en;

  // Select the single FIFO write for this cycle: deferred pad, completed pair, or flush pad.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (flush_pend) begin
      wr_en   = room;
      wr_data = {ZERO_FP16, half_r};
    end else if (accept) begin
      if (half_vld) begin
        wr_en   = 1'b1;
        wr_data = {sample, half_r};
      end else if (i_flush) begin
        wr_en   = 1'b1;
        wr_data = {ZERO_FP16, sample};
      end
    end else if (i_flush && half_vld) begin
      wr_en   = room;
      wr_data = {ZERO_FP16, half_r};
    end
  end

  // Half-word and pending-flush state. Because accepts are blocked while full, a half word
  // normally never meets a full FIFO; the deferred-pad path keeps flush safe regardless.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      half_vld   <= 1'b0;
      flush_pend <= 1'b0;
      half_r     <= '0;
    end else if (flush_pend) begin
      if (room) begin
        flush_pend <= 1'b0;
        half_vld   <= 1'b0;
      end
    end else if (accept) begin
      if (half_vld) begin
        half_vld <= 1'b0;
      end else if (!i_flush) begin
        half_vld <= 1'b1;
        half_r   <= sample;
      end
    end else if (i_flush && half_vld) begin
      if (room) half_vld   <= 1'b0;
      else      flush_pend <= 1'b1;
    end
  end

  mac_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (o_data),
    .count   (o_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_valid          = ~fifo_empty;
  assign o_empty          = fifo_empty & ~half_vld & ~flush_pend;
  assign o_transistor_num = '0;

endmodule

// File: tb/tb_mac_out_buf.sv
// Bench for mac_out_buf: two instances (ReLU off / on) share one stimulus stream and are checked
// every cycle against a queue-based model of the buffer, plus hand-computed literal words.
module tb_mac_out_buf;

  localparam int DEPTH = 8;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_conv;
  logic        i_flush;
  logic        i_ready;

  logic        o_inhibit0, o_valid0, o_empty0;
  logic [31:0] o_data0;
  logic [3:0]  o_count0;
  logic [50:0] o_tn0;
  logic        o_inhibit1, o_valid1, o_empty1;
  logic [31:0] o_data1;
  logic [3:0]  o_count1;
  logic [50:0] o_tn1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  mac_out_buf #(.DEPTH(DEPTH), .RELU_EN(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_conv(i_conv), .i_flush(i_flush),
    .o_inhibit(o_inhibit0), .o_valid(o_valid0), .o_data(o_data0), .i_ready(i_ready),
    .o_count(o_count0), .o_empty(o_empty0), .o_transistor_num(o_tn0)
  );

  mac_out_buf #(.DEPTH(DEPTH), .RELU_EN(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_conv(i_conv), .i_flush(i_flush),
    .o_inhibit(o_inhibit1), .o_valid(o_valid1), .o_data(o_data1), .i_ready(i_ready),
    .o_count(o_count1), .o_empty(o_empty1), .o_transistor_num(o_tn1)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          m_hv[2];
  logic [15:0] m_hd[2];
  bit          m_pend[2];
  bit          m_acc = 1'b0;
  bit          started = 1'b0;

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] q_front(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_push(input int k, input logic [31:0] w);
    if (k == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic q_pop(input int k);
    logic [31:0] tmp;
    if (k == 0) tmp = exp_q0.pop_front();
    else        tmp = exp_q1.pop_front();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the buffer as the behaviour rules describe it.
  task automatic model_step(input int k, input bit relu);
    int          sz;
    bit          inh, rd, acc, room;
    logic [15:0] s;
    sz   = q_size(k);
    inh  = (sz == DEPTH) || m_pend[k];
    rd   = (sz != 0) && i_ready;
    acc  = i_valid && !inh;
    room = (sz < DEPTH) || rd;
    s    = (relu && i_conv[15]) ? 16'h0000 : i_conv;
    if (rd) q_pop(k);
    if (m_pend[k]) begin
      if (room) begin
        q_push(k, {16'h0000, m_hd[k]});
        m_hv[k]   = 1'b0;
        m_pend[k] = 1'b0;
      end
    end else if (acc) begin
      if (m_hv[k]) begin
        q_push(k, {s, m_hd[k]});
        m_hv[k] = 1'b0;
      end else if (i_flush) begin
        q_push(k, {16'h0000, s});
      end else begin
        m_hv[k] = 1'b1;
        m_hd[k] = s;
      end
    end else if (i_flush && m_hv[k]) begin
      if (room) begin
        q_push(k, {16'h0000, m_hd[k]});
        m_hv[k] = 1'b0;
      end else begin
        m_pend[k] = 1'b1;
      end
    end
    if (k == 0) m_acc = acc;
  endtask

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_hv[k]   = 1'b0;
        m_pend[k] = 1'b0;
        m_hd[k]   = 16'h0000;
      end
      m_acc   = 1'b0;
      started = 1'b1;
    end else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  task automatic cmp_inst(input int k, input logic v, input logic [31:0] d, input logic [3:0] c,
                          input logic inh, input logic emp);
    int sz;
    sz = q_size(k);
    check($sformatf("valid%0d", k), {31'b0, v}, {31'b0, sz != 0});
    check($sformatf("count%0d", k), {28'b0, c}, sz);
    check($sformatf("inhibit%0d", k), {31'b0, inh}, {31'b0, (sz == DEPTH) || m_pend[k]});
    check($sformatf("empty%0d", k), {31'b0, emp}, {31'b0, (sz == 0) && !m_hv[k] && !m_pend[k]});
    if (sz != 0) check($sformatf("data%0d", k), d, q_front(k));
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge i_clk) begin
    if (started) begin
      cmp_inst(0, o_valid0, o_data0, o_count0, o_inhibit0, o_empty0);
      cmp_inst(1, o_valid1, o_data1, o_count1, o_inhibit1, o_empty1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] v, input bit fl);
    int n;
    i_valid = 1'b1;
    i_conv  = v;
    i_flush = fl;
    n = 0;
    do begin
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      n++;
    end while (!m_acc && n < 200);
    i_valid = 1'b0;
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic flush();
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    i_ready = 1'b1;
    n = 0;
    while ((q_size(0) != 0 || q_size(1) != 0) && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (q_size(0) != 0 || q_size(1) != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_conv  = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    cycles(2);

    // Reset state
    check("rst_valid", {31'b0, o_valid0}, 32'd0);
    check("rst_count", {28'b0, o_count0}, 32'd0);
    check("rst_empty", {31'b0, o_empty0}, 32'd1);
    check("rst_inhibit", {31'b0, o_inhibit0}, 32'd0);
    check("rst_data", o_data0, 32'd0);
    check("rst_tnum", o_tn0[31:0], 32'd0);
    i_rst_n = 1'b1;

    // Two samples pack into one word, visible right after the second accept edge
    i_ready = 1'b1;
    send(16'h3C00, 1'b0);
    check("t1_no_word_yet", {31'b0, o_valid0}, 32'd0);
    send(16'h4000, 1'b0);
    check("t1_model_word", exp_q0[0], 32'h40003C00);
    check("t1_valid", {31'b0, o_valid0}, 32'd1);
    check("t1_data", o_data0, 32'h40003C00);
    drain();

    // ReLU instance zeroes negatives including -0.0; plain instance keeps them
    i_ready = 1'b0;
    send(16'hBC00, 1'b0);
    send(16'h8000, 1'b0);
    send(16'h3800, 1'b0);
    send(16'h4400, 1'b0);
    check("t2_count", {28'b0, o_count1}, 32'd2);
    check("t2_relu_w0", o_data1, 32'h00000000);
    check("t2_plain_w0", o_data0, 32'h8000BC00);
    i_ready = 1'b1;
    cycles(1);
    check("t2_relu_w1", o_data1, 32'h44003800);
    drain();

    // Backpressure: 2*DEPTH samples fill the FIFO, inhibit drops after the first read
    i_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) send(16'((i << 12) | i), 1'b0);
    cycles(1);
    check("t3_full_count", {28'b0, o_count0}, 32'd8);
    check("t3_full_inhibit", {31'b0, o_inhibit0}, 32'd1);
    check("t3_head", o_data0, 32'h10010000);
    i_ready = 1'b1;
    cycles(1);
    check("t3_after_read_count", {28'b0, o_count0}, 32'd7);
    check("t3_after_read_inhibit", {31'b0, o_inhibit0}, 32'd0);
    drain();

    // Odd count then flush pads the last word; flush with no half word is a no-op
    i_ready = 1'b0;
    send(16'h1234, 1'b0);
    send(16'h2345, 1'b0);
    send(16'h3456, 1'b0);
    flush();
    check("t4_count", {28'b0, o_count0}, 32'd2);
    check("t4_w0", o_data0, 32'h23451234);
    i_ready = 1'b1;
    cycles(1);
    i_ready = 1'b0;
    check("t4_w1", o_data0, 32'h00003456);
    flush();
    cycles(1);
    check("t4_noop_flush", {28'b0, o_count0}, 32'd1);
    send(16'h4567, 1'b1);
    check("t4_same_cycle_pad", {28'b0, o_count0}, 32'd2);
    send(16'h5678, 1'b0);
    send(16'h6789, 1'b1);
    check("t4_pair_no_pad", {28'b0, o_count0}, 32'd3);
    drain();
    cycles(1);
    check("t4_empty", {31'b0, o_empty0}, 32'd1);

    // Flush filling the last slot, then flushes at full with no half word
    i_ready = 1'b0;
    for (int i = 0; i < 2 * (DEPTH - 1); i++) send(16'(16'h0A00 + i), 1'b0);
    send(16'h0BBB, 1'b0);
    check("t5_half_count", {28'b0, o_count0}, 32'd7);
    check("t5_half_not_empty", {31'b0, o_empty0}, 32'd0);
    flush();
    check("t5_pad_model", exp_q0[DEPTH-1], 32'h00000BBB);
    check("t5_full", {28'b0, o_count0}, 32'd8);
    check("t5_inhibit", {31'b0, o_inhibit0}, 32'd1);
    flush();
    flush();
    check("t5_absorbed", {28'b0, o_count0}, 32'd8);
    i_ready = 1'b1;
    cycles(1);
    i_ready = 1'b0;
    check("t5_one_read", {28'b0, o_count0}, 32'd7);
    drain();

    // Reset mid-operation discards everything
    i_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(16'(16'h2000 + i), 1'b0);
    i_rst_n = 1'b0;
    cycles(1);
    i_rst_n = 1'b1;
    check("t6_valid", {31'b0, o_valid0}, 32'd0);
    check("t6_count", {28'b0, o_count1}, 32'd0);
    check("t6_empty", {31'b0, o_empty0}, 32'd1);
    check("t6_inhibit", {31'b0, o_inhibit1}, 32'd0);
    i_ready = 1'b1;
    send(16'h7777, 1'b0);
    send(16'hC000, 1'b0);
    drain();
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
